// File: rtl/icache_pkg.sv
// Shared types, width helpers and address-field extraction for the instruction cache.
// Address layout: {tag, index, offset, 2'b00}.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam int BYTE_OFFSET_W      = 2;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_SETS       = 16;
  localparam int DEFAULT_LINE_WORDS = 4;

  function automatic int offset_width(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int data_width, input int sets, input int line_words);
    return data_width - index_width(sets) - offset_width(line_words) - BYTE_OFFSET_W;
  endfunction

  localparam int OFFSET_W = offset_width(DEFAULT_LINE_WORDS);
  localparam int INDEX_W  = index_width(DEFAULT_SETS);
  localparam int TAG_W    = tag_width(DEFAULT_DATA_WIDTH, DEFAULT_SETS, DEFAULT_LINE_WORDS);

  // Fields are extracted on a 64-bit view so one helper serves any address width.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ~(64'hFFFF_FFFF_FFFF_FFFF << width);
  endfunction

  function automatic logic [63:0] get_offset(input logic [63:0] addr, input int offset_w);
    return addr_field(addr, BYTE_OFFSET_W, offset_w);
  endfunction

  function automatic logic [63:0] get_index(input logic [63:0] addr, input int offset_w,
                                            input int index_w);
    return addr_field(addr, BYTE_OFFSET_W + offset_w, index_w);
  endfunction

  function automatic logic [63:0] get_tag(input logic [63:0] addr, input int offset_w,
                                          input int index_w, input int tag_w);
    return addr_field(addr, BYTE_OFFSET_W + offset_w + index_w, tag_w);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped storage: data words, tags and per-line valid bits.
// Combinational read; line-word, tag and valid updates happen on the clock edge.
module icache_array #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24,
  parameter int INDEX_W    = 4,
  parameter int OFFSET_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    i_rd_index,
  input  logic [OFFSET_W-1:0]   i_rd_offset,
  output logic [DATA_WIDTH-1:0] o_rd_word,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic                  o_rd_valid,
  input  logic                  i_wr_en,
  input  logic [INDEX_W-1:0]    i_wr_index,
  input  logic [OFFSET_W-1:0]   i_wr_offset,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_tag_wr_en,
  input  logic [TAG_W-1:0]      i_tag_wr_data,
  input  logic                  i_valid_clr_all
);

  logic [DATA_WIDTH-1:0] r_data  [SETS][LINE_WORDS];
  logic [TAG_W-1:0]      r_tag   [SETS];
  logic [SETS-1:0]       r_valid;

  assign o_rd_word  = r_data[i_rd_index][i_rd_offset];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_valid = r_valid[i_rd_index];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_index][i_wr_offset] <= i_wr_data;
    end
    if (i_tag_wr_en) begin
      r_tag[i_wr_index] <= i_tag_wr_data;
    end
  end

  // A bulk clear wins over setting the line just filled, so a pending flush discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_valid_clr_all) begin
      r_valid <= '0;
    end else if (i_tag_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache between the fetch PC and instruction memory.
// Hits answer in the same cycle; misses refill the whole line word-serially from word 0.
import icache_pkg::*;

module icache_fetch #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SETS       = DEFAULT_SETS,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC,
  input  logic                  fetch_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  stall,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int LINE_OFFSET_W = offset_width(LINE_WORDS);
  localparam int SET_INDEX_W   = index_width(SETS);
  localparam int LINE_TAG_W    = tag_width(DATA_WIDTH, SETS, LINE_WORDS);

  logic [LINE_OFFSET_W-1:0] w_offset;
  logic [SET_INDEX_W-1:0]   w_index;
  logic [LINE_TAG_W-1:0]    w_tag;
  logic [DATA_WIDTH-1:0]    w_rd_word;
  logic [LINE_TAG_W-1:0]    w_rd_tag;
  logic                     w_rd_valid;
  logic                     w_hit;
  logic                     w_miss;
  logic                     w_fill_ack;
  logic                     w_last_beat;
  logic                     w_clear_valid;

  state_t                   r_state;
  logic [LINE_OFFSET_W-1:0] r_beat;
  logic [LINE_TAG_W-1:0]    r_miss_tag;
  logic [SET_INDEX_W-1:0]   r_miss_index;
  logic                     r_pending_flush;
  logic                     r_mem_req;

  assign w_offset = LINE_OFFSET_W'(get_offset(64'(PC), LINE_OFFSET_W));
  assign w_index  = SET_INDEX_W'(get_index(64'(PC), LINE_OFFSET_W, SET_INDEX_W));
  assign w_tag    = LINE_TAG_W'(get_tag(64'(PC), LINE_OFFSET_W, SET_INDEX_W, LINE_TAG_W));

  // Lookup is gated by reset so every output reads zero while reset is held.
  assign w_hit  = !rst && (r_state == IDLE) && fetch_en && w_rd_valid && (w_rd_tag == w_tag);
  assign w_miss = !rst && (r_state == IDLE) && fetch_en && !w_hit;

  assign w_fill_ack    = (r_state == REFILL) && mem_ack;
  assign w_last_beat   = w_fill_ack && (r_beat == LINE_OFFSET_W'(LINE_WORDS - 1));
  assign w_clear_valid = ((r_state == IDLE) && flush) ||
                         (w_last_beat && (r_pending_flush || flush));

  assign instr       = w_hit ? w_rd_word : '0;
  assign instr_valid = w_hit;
  assign stall       = w_miss || (r_state == REFILL);
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_req ? {r_miss_tag, r_miss_index, r_beat, 2'b00} : '0;

  icache_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (LINE_TAG_W),
    .INDEX_W    (SET_INDEX_W),
    .OFFSET_W   (LINE_OFFSET_W)
  ) u_array (
    .clk             (clk),
    .rst             (rst),
    .i_rd_index      (w_index),
    .i_rd_offset     (w_offset),
    .o_rd_word       (w_rd_word),
    .o_rd_tag        (w_rd_tag),
    .o_rd_valid      (w_rd_valid),
    .i_wr_en         (w_fill_ack),
    .i_wr_index      (r_miss_index),
    .i_wr_offset     (r_beat),
    .i_wr_data       (mem_rdata),
    .i_tag_wr_en     (w_last_beat),
    .i_tag_wr_data   (r_miss_tag),
    .i_valid_clr_all (w_clear_valid)
  );

  // The refill always runs to the last beat of the latched line; PC and flush cannot cut it short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_beat          <= '0;
      r_miss_tag      <= '0;
      r_miss_index    <= '0;
      r_pending_flush <= 1'b0;
      r_mem_req       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_miss_tag      <= w_tag;
            r_miss_index    <= w_index;
            r_beat          <= '0;
            r_pending_flush <= 1'b0;
            r_mem_req       <= 1'b1;
            r_state         <= REFILL;
          end
        end
        REFILL: begin
          if (flush) begin
            r_pending_flush <= 1'b1;
          end
          if (mem_ack) begin
            r_beat <= r_beat + LINE_OFFSET_W'(1);
          end
          if (w_last_beat) begin
            r_pending_flush <= 1'b0;
            r_mem_req       <= 1'b0;
            r_state         <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: a line-level cache model checks outputs every cycle,
// while literal expectations pin the documented scenarios.
module tb_icache_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic        fetch_en;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int ackPeriod = 1;
  int reqCount = 0;

  // Model state: which line number lives in each set, and the refill in flight.
  longint resident [16];
  bit     filling;
  longint fillLine;
  int     gotWords;
  bit     pendFlush;

  icache_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .PC          (PC),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'hA0 + {28'b0, a[3:2]};
    return 32'hC0DE0000 | {a[31:2], 2'b00};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) resident[i] = -1;
    filling   = 1'b0;
    fillLine  = 0;
    gotWords  = 0;
    pendFlush = 1'b0;
  endtask

  task automatic modelClearAll();
    for (int i = 0; i < 16; i++) resident[i] = -1;
  endtask

  task automatic modelStep();
    longint lineNo;
    bit     hitNow;
    if (filling) begin
      if (flush) pendFlush = 1'b1;
      if (mem_ack) begin
        gotWords++;
        if (gotWords == 4) begin
          filling = 1'b0;
          if (pendFlush) modelClearAll();
          else resident[fillLine % 16] = fillLine;
          pendFlush = 1'b0;
        end
      end
    end else begin
      lineNo = longint'(PC >> 4);
      hitNow = fetch_en && (resident[lineNo % 16] == lineNo);
      if (fetch_en && !hitNow) begin
        filling   = 1'b1;
        fillLine  = lineNo;
        gotWords  = 0;
        pendFlush = 1'b0;
      end
      if (flush) modelClearAll();
    end
  endtask

  task automatic modelCompare();
    longint      lineNo;
    bit          hitNow;
    logic [31:0] expInstr, expAddr;
    logic        expValid, expStall, expReq;
    expInstr = '0; expAddr = '0; expValid = 1'b0; expStall = 1'b0; expReq = 1'b0;
    if (!rst) begin
      if (filling) begin
        expStall = 1'b1;
        expReq   = 1'b1;
        expAddr  = 32'(fillLine * 16 + gotWords * 4);
      end else begin
        lineNo = longint'(PC >> 4);
        hitNow = fetch_en && (resident[lineNo % 16] == lineNo);
        expValid = hitNow;
        expStall = fetch_en && !hitNow;
        if (hitNow) expInstr = memWord({PC[31:2], 2'b00});
      end
    end
    checkOutput("model instr_valid", {31'b0, instr_valid}, {31'b0, expValid});
    checkOutput("model instr", instr, expInstr);
    checkOutput("model stall", {31'b0, stall}, {31'b0, expStall});
    checkOutput("model mem_req", {31'b0, mem_req}, {31'b0, expReq});
    checkOutput("model mem_addr", mem_addr, expAddr);
  endtask

  // Model advances on the rising edge and is compared on the falling edge.
  initial begin
    modelReset();
    forever begin
      @(posedge clk);
      if (rst) modelReset();
      else modelStep();
      @(negedge clk);
      if (rst) modelReset();
      modelCompare();
    end
  end

  // Memory responder: acknowledges every ackPeriod-th cycle of a continuous request.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && !rst) begin
        reqCount++;
        if (reqCount % ackPeriod == 0) begin
          mem_ack = 1'b1;
          mem_rdata = memWord(mem_addr);
        end else begin
          mem_ack = 1'b0;
          mem_rdata = '0;
        end
      end else begin
        reqCount = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic en, input logic [31:0] pc, input logic fl);
    @(posedge clk);
    #1;
    fetch_en = en;
    PC = pc;
    flush = fl;
    #1;
  endtask

  task automatic waitForHit(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput(name, {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    int reqCycles;
    logic [31:0] lastAddr;
    rst = 1'b1;
    fetch_en = 1'b0;
    flush = 1'b0;
    PC = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("reset stall", {31'b0, stall}, 32'd0);
    checkOutput("reset instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    // Cold miss: one miss cycle, four refill beats, hit on the sixth cycle.
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("t1 miss stall", {31'b0, stall}, 32'd1);
    checkOutput("t1 miss no req yet", {31'b0, mem_req}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2;
      checkOutput("t1 refill stall", {31'b0, stall}, 32'd1);
      checkOutput("t1 refill addr", mem_addr, 32'h100 + 32'(4 * k));
    end
    @(posedge clk);
    #2;
    checkOutput("t1 hit valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("t1 hit instr", instr, 32'hA0);
    checkOutput("t1 hit stall", {31'b0, stall}, 32'd0);

    // Back-to-back hits in the freshly filled line.
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * k), 1'b0);
      checkOutput("t2 hit instr", instr, 32'hA0 + 32'(k));
      checkOutput("t2 hit stall", {31'b0, stall}, 32'd0);
      checkOutput("t2 hit no req", {31'b0, mem_req}, 32'd0);
    end

    // Conflict: 0x200 shares index 0 with 0x100.
    applyStimulus(1'b1, 32'h200, 1'b0);
    checkOutput("t3 conflict stall", {31'b0, stall}, 32'd1);
    waitForHit("t3 fill 0x200 completes");
    checkOutput("t3 instr 0x200", instr, 32'hC0DE0200);
    ackPeriod = 3;
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("t3 evicted 0x100 misses", {31'b0, stall}, 32'd1);

    // Slow memory with the PC moving away mid-refill.
    reqCycles = 0;
    lastAddr = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) PC = 32'h300;
      #1;
      if (!mem_req) break;
      reqCycles++;
      lastAddr = mem_addr;
    end
    checkOutput("t4 req cycles", 32'(reqCycles), 32'd12);
    checkOutput("t4 last beat addr", lastAddr, 32'h10C);
    checkOutput("t4 0x300 misses", {31'b0, stall}, 32'd1);
    checkOutput("t4 0x300 not valid", {31'b0, instr_valid}, 32'd0);
    ackPeriod = 1;
    waitForHit("t4 fill 0x300 completes");
    checkOutput("t4 instr 0x300", instr, 32'hC0DE0300);

    // Flush during refill beat 2 discards the line being filled.
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("t5 miss stall", {31'b0, stall}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      flush = (k == 2);
      #1;
      checkOutput("t5 refill addr", mem_addr, 32'h100 + 32'(4 * k));
    end
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("t5 flushed line misses", {31'b0, stall}, 32'd1);
    checkOutput("t5 flushed line invalid", {31'b0, instr_valid}, 32'd0);
    waitForHit("t5 refetch completes");
    checkOutput("t5 refetch instr", instr, 32'hA0);
    applyStimulus(1'b1, 32'h104, 1'b1);
    checkOutput("t5 lookup during flush", instr, 32'hA1);
    applyStimulus(1'b1, 32'h108, 1'b0);
    checkOutput("t5 post-flush miss", {31'b0, stall}, 32'd1);
    waitForHit("t5 post-flush refill completes");
    checkOutput("t5 post-flush instr", instr, 32'hA2);

    // Reset after beat 1 of a refill.
    applyStimulus(1'b1, 32'h200, 1'b0);
    checkOutput("t6 miss stall", {31'b0, stall}, 32'd1);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6 reset mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("t6 reset stall", {31'b0, stall}, 32'd0);
    checkOutput("t6 reset mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    PC = 32'h100;
    #1;
    checkOutput("t6 after reset misses", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #2;
    checkOutput("t6 refetch addr", mem_addr, 32'h100);
    waitForHit("t6 refetch completes");
    checkOutput("t6 refetch instr", instr, 32'hA0);

    applyStimulus(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
